// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Purpose  : Shared widths, reset PC, NOP encoding and the fetch queue entry
//            type used by the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  localparam int unsigned          c_ADDR_W    = 32;
  localparam int unsigned          c_INSTR_W   = 32;
  localparam logic [c_ADDR_W-1:0]  c_RESET_PC  = '0;
  localparam logic [c_INSTR_W-1:0] c_NOP_INSTR = 32'h0000_0013;

  // One prefetch queue slot: the instruction and the PC it was fetched from.
  typedef struct packed {
    logic [c_ADDR_W-1:0]  pc;
    logic [c_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction memory is word addressed; low two address bits are dropped.
  function automatic logic [c_ADDR_W-1:0] word_align(input logic [c_ADDR_W-1:0] addr);
    return addr & ~c_ADDR_W'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Bundles the instruction-memory, redirect and ID-stage handshake
//            signals of the fetch stage. master = fetch unit, slave = its
//            environment (memory, EX redirect source, ID stage).
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W  = instr_fetch_unit_pkg::c_ADDR_W,
  parameter int unsigned INSTR_W = instr_fetch_unit_pkg::c_INSTR_W
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_instr,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_instr,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small power-of-two FIFO with synchronous clear and occupancy
//            count. Payload type is a parameter so the same block serves as
//            the PC tag queue and the instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  wire                               clk,
  input  wire                               reset,
  input  wire                               push_i,
  input  wire T                             push_data_i,
  input  wire                               pop_i,
  input  wire                               clear_i,
  output T                                  head_o,
  output logic [$clog2(DEPTH+1)-1:0]        count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  T                   mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_q;
  logic [PTR_W-1:0]   wr_q;
  logic [CNT_W-1:0]   count_q;

  // Pointers and count; clear wins over push/pop so a flush leaves it empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage needs no reset: nothing is read until the count says it is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Upstream credit accounting must never let a push land on a full queue.
  always @(posedge clk) begin
    if (reset && !clear_i && push_i && !pop_i) begin
      assert (count_q != CNT_W'(DEPTH));
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : IF stage. Owns the PC, issues in-order instruction memory reads
//            limited by prefetch-queue credit, tags returns with their PC and
//            presents {pc,instr} to ID under valid/ready. An EX redirect
//            flushes everything and discards responses still in flight.
//            Define FETCH_STATS_EN to add saturating stat_fetched /
//            stat_dropped counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = c_ADDR_W,
  parameter int unsigned       INSTR_W  = c_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = c_RESET_PC
) (
  input  wire                  clk,
  input  wire                  reset,
  instr_fetch_unit_if.master   bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]          stat_fetched,
  output logic [31:0]          stat_dropped
`endif
);

  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  // Responses still owed from before a redirect; memory latency bounds this.
  localparam int unsigned DROP_W = 8;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0]  w_occ;
  logic [CNT_W-1:0]  w_outst;
  logic [CNT_W:0]    w_used;
  logic              w_req;
  logic              w_accept;
  logic              w_discard;
  logic              w_pop;
  logic              w_head_valid;
  logic [ADDR_W-1:0] w_tag_head;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head;

  // Credit = DEPTH - queued - outstanding; requests stop while a redirect is live.
  assign w_used       = {1'b0, w_occ} + {1'b0, w_outst};
  assign w_req        = reset && !bus.redirect_valid && (w_used < (CNT_W+1)'(DEPTH));
  assign w_accept     = bus.imem_rvalid && !bus.redirect_valid && (drop_q == '0);
  assign w_discard    = bus.imem_rvalid && (bus.redirect_valid || (drop_q != '0));
  assign w_head_valid = (w_occ != '0);
  assign w_pop        = w_head_valid && bus.id_ready && !bus.redirect_valid;

  assign w_push_entry.pc    = w_tag_head;
  assign w_push_entry.instr = bus.imem_rdata;

  // PCs of requests awaiting their response, oldest first.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [ADDR_W-1:0])
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_req),
    .push_data_i (pc_q),
    .pop_i       (w_accept),
    .clear_i     (bus.redirect_valid),
    .head_o      (w_tag_head),
    .count_o     (w_outst)
  );

  // Returned instructions waiting for ID.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_instr_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (w_accept),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .clear_i     (bus.redirect_valid),
    .head_o      (w_head),
    .count_o     (w_occ)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = w_head_valid;
  assign bus.id_pc     = w_head_valid ? w_head.pc    : {ADDR_W{1'b0}};
  assign bus.id_instr  = w_head_valid ? w_head.instr : {INSTR_W{1'b0}};

  // Next PC and drop count; a redirect owes every in-flight response except
  // one arriving in the same cycle, which is discarded on the spot.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (bus.redirect_valid) begin
      pc_d   = word_align(bus.redirect_pc);
      drop_d = drop_q + DROP_W'(w_outst) - DROP_W'(bus.imem_rvalid);
    end else begin
      if (w_req)     pc_d   = pc_q + ADDR_W'(4);
      if (w_discard) drop_d = drop_q - DROP_W'(1);
    end
  end

  // PC and drop-count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating counts of instructions handed to ID and responses thrown away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_dropped <= '0;
    end else begin
      if (w_pop && (stat_fetched != '1))     stat_fetched <= stat_fetched + 32'd1;
      if (w_discard && (stat_dropped != '1)) stat_dropped <= stat_dropped + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
